// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Round-robin arbiter that shares one memory read/write channel between
// NUM_CONSUMERS requesters. Exactly one request is in flight at a time.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   consumer_read_valid/_address    per-consumer read requests (flat vectors)
//   consumer_write_valid/_address/_data  per-consumer write requests
//   consumer_read_ready/_data       one-cycle read completion + returned data
//   consumer_write_ready            one-cycle write completion
//   mem_read_valid/_address, mem_read_ready/_data    memory read channel
//   mem_write_valid/_address/_data, mem_write_ready  memory write channel
//   busy                            high whenever the FSM is not in IDLE
//   grant_id                        consumer currently (or last) served
//   timeout_err                     one-cycle pulse when a request is aborted
//   state_dbg                       raw FSM state for debug/checkers
//
// Handshake semantics (all channels):
//   A requester raises valid and holds it, together with its address/data,
//   until it samples the matching ready high; it drops valid on that same
//   edge. ready is a single-cycle completion pulse. Toward memory, the
//   arbiter holds mem_*_valid and the registered address/data stable until
//   mem_*_ready is sampled high or the wait counter expires.
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0]              consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]    consumer_read_address,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]    consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]    consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0]              consumer_write_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]    consumer_read_data,
  output logic                                  mem_read_valid,
  input  logic                                  mem_read_ready,
  output logic [ADDR_BITS-1:0]                  mem_read_address,
  input  logic [DATA_BITS-1:0]                  mem_read_data,
  output logic                                  mem_write_valid,
  input  logic                                  mem_write_ready,
  output logic [ADDR_BITS-1:0]                  mem_write_address,
  output logic [DATA_BITS-1:0]                  mem_write_data,
  output logic                                  busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]      grant_id,
  output logic                                  timeout_err,
  output logic [1:0]                            state_dbg
);

  localparam int GW       = $clog2(NUM_CONSUMERS);
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

  // Wait-counter value seen in the last WAIT cycle before abort: the counter
  // reaches TIMEOUT_CYCLES on the edge that aborts the request.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]       LAST_ID  = GW'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [GW-1:0]                       rr_ptr_q;
  logic [GW-1:0]                       grant_q;
  logic [CNT_BITS-1:0]                 wait_cnt_q;
  logic                                mem_rd_valid_q;
  logic                                mem_wr_valid_q;
  logic [ADDR_BITS-1:0]                mem_rd_addr_q;
  logic [ADDR_BITS-1:0]                mem_wr_addr_q;
  logic [DATA_BITS-1:0]                mem_wr_data_q;
  logic [NUM_CONSUMERS-1:0]            rd_ready_q;
  logic [NUM_CONSUMERS-1:0]            wr_ready_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0]  rd_data_q;
  logic                                timeout_q;

  // Effective request vectors; write requests vanish entirely when writes
  // are disabled so they can never win the scan.
  logic [NUM_CONSUMERS-1:0] rd_req;
  logic [NUM_CONSUMERS-1:0] wr_req;

  assign rd_req = consumer_read_valid;
  assign wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  // Round-robin scan starting at rr_ptr_q and wrapping modulo NUM_CONSUMERS.
  logic          scan_found;
  logic [GW-1:0] scan_idx;

  always_comb begin : scan
    int            idx;
    logic [GW-1:0] sel;
    scan_found = 1'b0;
    scan_idx   = '0;
    idx        = 0;
    sel        = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      sel = GW'(idx);
      if (!scan_found && (rd_req[sel] || wr_req[sel])) begin
        scan_found = 1'b1;
        scan_idx   = sel;
      end
    end
  end

  // Read wins over write within the granted consumer.
  logic grant_is_read;
  assign grant_is_read = rd_req[scan_idx];

  // FSM next-state and control strobes.
  logic do_grant;
  logic done_ok;
  logic done_to;

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_found) begin
          do_grant = 1'b1;
          state_d  = grant_is_read ? READ_WAIT : WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          done_ok = 1'b1;
          state_d = RELAY;
        end else if (wait_cnt_q == CNT_LAST) begin
          done_to = 1'b1;
          state_d = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          done_ok = 1'b1;
          state_d = RELAY;
        end else if (wait_cnt_q == CNT_LAST) begin
          done_to = 1'b1;
          state_d = RELAY;
        end
      end
      RELAY: begin
        // No grant here: the served consumer is only now dropping valid.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      wait_cnt_q     <= '0;
      mem_rd_valid_q <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      rd_ready_q     <= '0;
      wr_ready_q     <= '0;
      rd_data_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      // Completion strobes are single-cycle by construction.
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      timeout_q  <= 1'b0;

      if (do_grant) begin
        grant_q    <= scan_idx;
        wait_cnt_q <= '0;
        if (grant_is_read) begin
          mem_rd_valid_q <= 1'b1;
          mem_rd_addr_q  <= consumer_read_address[scan_idx*ADDR_BITS +: ADDR_BITS];
        end else begin
          mem_wr_valid_q <= 1'b1;
          mem_wr_addr_q  <= consumer_write_address[scan_idx*ADDR_BITS +: ADDR_BITS];
          mem_wr_data_q  <= consumer_write_data[scan_idx*DATA_BITS +: DATA_BITS];
        end
      end

      if (state_q == READ_WAIT || state_q == WRITE_WAIT) begin
        if (!done_ok) wait_cnt_q <= wait_cnt_q + 1'b1;
        if (done_ok || done_to) begin
          mem_rd_valid_q <= 1'b0;
          mem_wr_valid_q <= 1'b0;
          timeout_q      <= done_to;
          if (state_q == READ_WAIT) begin
            rd_ready_q[grant_q] <= 1'b1;
            // An aborted read returns zero rather than whatever is on the bus.
            rd_data_q[grant_q*DATA_BITS +: DATA_BITS] <= done_ok ? mem_read_data : '0;
          end else begin
            wr_ready_q[grant_q] <= 1'b1;
          end
        end
      end

      if (state_q == RELAY) begin
        rr_ptr_q <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
  assign consumer_read_data   = rd_data_q;
  assign mem_read_valid       = mem_rd_valid_q;
  assign mem_read_address     = mem_rd_addr_q;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wr_valid_q : 1'b0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? mem_wr_addr_q : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? mem_wr_data_q : '0;
  assign busy                 = (state_q != IDLE);
  assign grant_id             = grant_q;
  assign timeout_err          = timeout_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Testbench for mem_rr_arbiter. The bench plays every consumer and the
// memory; a transaction-level model (round-robin pointer, pending flags,
// last returned read data per consumer) predicts each grant and completion.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;
  localparam int GW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (writes enabled, short timeout) ----------------
  logic [N-1:0]    crv, cwv, c_rr, c_wr;
  logic [N*AW-1:0] cra, cwa;
  logic [N*DW-1:0] cwd, crd;
  logic            mrv, mwv, mrr, mwr;
  logic [AW-1:0]   mra, mwa;
  logic [DW-1:0]   mrd, mwd;
  logic            busy, terr;
  logic [GW-1:0]   gid;
  logic [1:0]      sdbg;

  mem_rr_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N),
    .WRITE_ENABLE(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_write_valid(cwv),
    .consumer_read_address(cra), .consumer_write_address(cwa),
    .consumer_write_data(cwd),
    .consumer_read_ready(c_rr), .consumer_write_ready(c_wr),
    .consumer_read_data(crd),
    .mem_read_valid(mrv), .mem_read_ready(mrr),
    .mem_read_address(mra), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_ready(mwr),
    .mem_write_address(mwa), .mem_write_data(mwd),
    .busy(busy), .grant_id(gid), .timeout_err(terr), .state_dbg(sdbg)
  );

  // ---------------- second DUT (writes disabled) ----------------
  logic [N-1:0]    nw_crv, nw_cwv, nw_crr, nw_cwr;
  logic [N*AW-1:0] nw_cra, nw_cwa;
  logic [N*DW-1:0] nw_cwd, nw_crd;
  logic            nw_mrv, nw_mwv, nw_mrr, nw_mwr;
  logic [AW-1:0]   nw_mra, nw_mwa;
  logic [DW-1:0]   nw_mrd, nw_mwd;
  logic            nw_busy, nw_terr;
  logic [GW-1:0]   nw_gid;
  logic [1:0]      nw_sdbg;

  mem_rr_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N),
    .WRITE_ENABLE(0), .TIMEOUT_CYCLES(255)
  ) dut_nw (
    .clk(clk), .reset(reset),
    .consumer_read_valid(nw_crv), .consumer_write_valid(nw_cwv),
    .consumer_read_address(nw_cra), .consumer_write_address(nw_cwa),
    .consumer_write_data(nw_cwd),
    .consumer_read_ready(nw_crr), .consumer_write_ready(nw_cwr),
    .consumer_read_data(nw_crd),
    .mem_read_valid(nw_mrv), .mem_read_ready(nw_mrr),
    .mem_read_address(nw_mra), .mem_read_data(nw_mrd),
    .mem_write_valid(nw_mwv), .mem_write_ready(nw_mwr),
    .mem_write_address(nw_mwa), .mem_write_data(nw_mwd),
    .busy(nw_busy), .grant_id(nw_gid), .timeout_err(nw_terr), .state_dbg(nw_sdbg)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            neg_cnt  = 0;
  int            relay_at = 0;
  int            ptr_m    = 0;
  logic [DW-1:0] exp_rd [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All sampling and driving happens on the falling edge.
  task automatic step();
    @(negedge clk);
    neg_cnt++;
  endtask

  // Next consumer to be served: first one holding any valid, scanning from
  // the model pointer with wrap-around.
  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ptr_m + i) % N;
      if (crv[c] || cwv[c]) return c;
    end
    return -1;
  endfunction

  task automatic add_reqs(input int skip);
    for (int c = 0; c < N; c++) begin
      if (c != skip) begin
        if (!crv[c] && $urandom_range(0, 3) == 0) begin
          crv[c] = 1'b1;
          cra[c*AW +: AW] = AW'($urandom);
        end
        if (!cwv[c] && $urandom_range(0, 3) == 0) begin
          cwv[c] = 1'b1;
          cwa[c*AW +: AW] = AW'($urandom);
          cwd[c*DW +: DW] = DW'($urandom);
        end
      end
    end
  endtask

  // One complete transaction, entered at a falling edge with the DUT idle.
  // lat = number of WAIT cycles before memory answers; lat >= TO never answers.
  task automatic do_txn(input int lat, input logic [DW-1:0] mdata, input logic noise);
    int            g;
    int            kend;
    logic          is_rd;
    logic          tmo;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    g = pick();
    if (g < 0) return;
    is_rd = crv[g];
    ea    = is_rd ? cra[g*AW +: AW] : cwa[g*AW +: AW];
    ed    = cwd[g*DW +: DW];
    tmo   = (lat >= TO);
    kend  = tmo ? TO - 1 : lat;

    for (int k = 0; k <= kend; k++) begin
      step();
      chk("wait_busy", busy, 1);
      chk("grant_id", gid, g);
      chk("mem_read_valid", mrv, is_rd);
      chk("mem_write_valid", mwv, !is_rd);
      if (is_rd) chk("mem_read_address", mra, ea);
      else begin
        chk("mem_write_address", mwa, ea);
        chk("mem_write_data", mwd, ed);
      end
      chk("wait_no_ready", {c_rr, c_wr}, 0);
      // The in-flight request's inputs wander; the memory side must not.
      if (is_rd) cra[g*AW +: AW] = AW'($urandom);
      else begin
        cwa[g*AW +: AW] = AW'($urandom);
        cwd[g*DW +: DW] = DW'($urandom);
      end
      mrr = is_rd && (k == lat);
      mwr = !is_rd && (k == lat);
      mrd = (k == lat) ? mdata : DW'($urandom);
      if (noise) add_reqs(g);
    end

    step();  // completion cycle
    relay_at = neg_cnt;
    chk("read_ready", c_rr, is_rd ? (4'b0001 << g) : 4'b0000);
    chk("write_ready", c_wr, is_rd ? 4'b0000 : (4'b0001 << g));
    chk("timeout_err", terr, tmo);
    chk("relay_mem_valid", {mrv, mwv}, 0);
    chk("relay_busy", busy, 1);
    if (is_rd) exp_rd[g] = tmo ? '0 : mdata;
    for (int c = 0; c < N; c++) chk("read_data", crd[c*DW +: DW], exp_rd[c]);
    if (is_rd) crv[g] = 1'b0;
    else       cwv[g] = 1'b0;
    ptr_m = (g + 1) % N;
    // Memory chatter outside WAIT must be ignored.
    mrr = 1'($urandom);
    mwr = 1'($urandom);
    mrd = DW'($urandom);
    if (noise) add_reqs(g);

    step();  // back in IDLE
    chk("idle_busy", busy, 0);
    chk("idle_ready", {c_rr, c_wr}, 0);
    chk("idle_timeout_err", terr, 0);
    chk("idle_mem_valid", {mrv, mwv}, 0);
    mrr = 1'($urandom);
    mwr = 1'($urandom);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int prev;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = 0; mwr = 0; mrd = '0;
    nw_crv = '0; nw_cwv = '0; nw_cra = '0; nw_cwa = '0; nw_cwd = '0;
    nw_mrr = 1'b1; nw_mwr = 1'b1; nw_mrd = 16'h5A5A;
    for (int c = 0; c < N; c++) exp_rd[c] = '0;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", {mrv, mwv}, 0);
    chk("rst_ready", {c_rr, c_wr}, 0);
    chk("rst_grant_id", gid, 0);
    chk("rst_timeout_err", terr, 0);
    chk("rst_read_data", crd, 0);
    chk("rst_addr", {mra, mwa, mwd}, 0);
    reset = 1'b0;

    // Fairness: all read, zero-wait memory -> 0,1,2,3, three cycles apart
    for (int c = 0; c < N; c++) begin
      crv[c] = 1'b1;
      cra[c*AW +: AW] = AW'(8'h40 + c);
    end
    prev = 0;
    for (int t = 0; t < N; t++) begin
      chk("fair_order", pick(), t);
      do_txn(0, DW'(16'hA000 + t), 1'b0);
      if (t > 0) chk("fair_spacing", relay_at - prev, 3);
      prev = relay_at;
    end
    // Pointer back at 0: consumers 3 and 0 both ask, 0 must win
    crv[3] = 1'b1; cra[3*AW +: AW] = 8'h33;
    crv[0] = 1'b1; cra[0*AW +: AW] = 8'h30;
    do_txn(1, 16'h0C0C, 1'b0);
    chk("wrap_ptr_zero", crv[0], 0);
    do_txn(0, 16'h0303, 1'b0);

    // Single read: consumer 2, addr 0x10, memory answers 0xBEEF
    crv[2] = 1'b1; cra[2*AW +: AW] = 8'h10;
    do_txn(2, 16'hBEEF, 1'b0);

    // Read and write on consumer 1: read first, write on the next grant
    crv[1] = 1'b1; cra[1*AW +: AW] = 8'h21;
    cwv[1] = 1'b1; cwa[1*AW +: AW] = 8'h20; cwd[1*DW +: DW] = 16'h1234;
    do_txn(0, 16'h7777, 1'b0);
    chk("rw_write_pending", cwv[1], 1);
    do_txn(1, 16'h0000, 1'b0);

    // Timeout on a read (memory never answers)
    crv[0] = 1'b1; cra[0*AW +: AW] = 8'h99;
    do_txn(9, 16'hDEAD, 1'b0);

    // Reset mid-READ_WAIT; pointer was 1 before, must restart at 0
    crv[1] = 1'b1; cra[1*AW +: AW] = 8'h55;
    mrr = 1'b0; mwr = 1'b0;
    step();
    chk("pre_rst_read_valid", mrv, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_read_valid", mrv, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", {c_rr, c_wr}, 0);
    chk("mid_rst_read_data", crd, 0);
    reset = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < N; c++) exp_rd[c] = '0;
    crv[3] = 1'b1; cra[3*AW +: AW] = 8'h3E;
    chk("post_rst_pick", pick(), 1);
    do_txn(0, 16'h1111, 1'b0);
    do_txn(3, 16'h3333, 1'b0);

    // Randomized traffic, including timeouts and late arrivals
    for (int t = 0; t < 250; t++) begin
      if (pick() < 0) begin
        step();
        chk("rand_idle_busy", busy, 0);
        add_reqs(-1);
        if (pick() < 0) begin
          crv[t % N] = 1'b1;
          cra[(t % N)*AW +: AW] = AW'($urandom);
        end
      end
      do_txn($urandom_range(0, 6), DW'($urandom), 1'b1);
    end

    // Writes disabled: a held write request is never served
    nw_cwv[0] = 1'b1; nw_cwa[0*AW +: AW] = 8'h44; nw_cwd[0*DW +: DW] = 16'hCAFE;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("nw_busy", nw_busy, 0);
      chk("nw_mem_write_valid", nw_mwv, 0);
      chk("nw_write_ready", nw_cwr, 0);
    end
    nw_crv[1] = 1'b1; nw_cra[1*AW +: AW] = 8'h61;
    step();
    chk("nw_read_grant", {nw_mrv, nw_gid}, {1'b1, 2'd1});
    chk("nw_read_addr", nw_mra, 8'h61);
    step();
    chk("nw_read_ready", nw_crr, 4'b0010);
    chk("nw_read_data", nw_crd[1*DW +: DW], 16'h5A5A);
    nw_crv[1] = 1'b0;
    step();
    step();
    chk("nw_final_busy", nw_busy, 0);
    chk("nw_final_mem_write_valid", nw_mwv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
